// File: rtl/cbuf_acq_sequencer.sv
// cbuf_acq_sequencer
//   Control sequencer for circular-buffer acquisition. Each accepted trigger
//   emits one fill header, one waveform header, N data bursts and one
//   checksum, one FIFO word per cycle. It drives the select and checksum
//   strobes of the downstream ADC data mux.
//
//   Optional feature macro: CBUF_DROP_COUNT_EN adds the dropped_count port
//   and a saturating counter of rejected triggers.
//
// Ports
//   clk, rst            acquisition clock, asynchronous active-high reset
//   trig, enable        trigger pulse, acquisition enable
//   async_num_bursts    data bursts per fill (latched on accept)
//   cbuf_wr_adr         circular-buffer write address (latched on accept)
//   fifo_prog_full      DDR3 write FIFO programmable-full flag
//   select_*            one-hot mux selects (Moore, from registered state)
//   checksum_update     mux XORs data into its checksum
//   fifo_wr_en          registered OR of the selects
//   burst_start_adr     start address of the current fill
//   fill_num            fill counter, advances as CKSUM ends
//   busy                high outside IDLE
//   trig_dropped        one-cycle pulse for a rejected trigger
//   dropped_count       saturating rejected-trigger count (macro only)
module cbuf_acq_sequencer #(
  parameter int NB_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trig,
  input  logic            enable,
  input  logic [NB_W-1:0] async_num_bursts,
  input  logic [22:0]     cbuf_wr_adr,
  input  logic            fifo_prog_full,
  output logic            select_fill_hdr,
  output logic            select_waveform_hdr,
  output logic            select_dat,
  output logic            select_checksum,
  output logic            checksum_update,
  output logic            fifo_wr_en,
  output logic [22:0]     burst_start_adr,
  output logic [23:0]     fill_num,
  output logic            busy,
`ifdef CBUF_DROP_COUNT_EN
  output logic            trig_dropped,
  output logic [15:0]     dropped_count
`else
  output logic            trig_dropped
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL_HDR = 3'd1,
    WFM_HDR  = 3'd2,
    DATA     = 3'd3,
    CKSUM    = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [NB_W-1:0] nb_left_r;
  logic            accept_s;
  logic            drop_s;

  // A trigger outside IDLE, or in IDLE while the FIFO is nearly full, is
  // rejected loudly; a trigger with enable low in IDLE is silently ignored.
  assign accept_s = (state_r == IDLE) && trig && enable && !fifo_prog_full;
  assign drop_s   = trig && ((state_r != IDLE) || (enable && fifo_prog_full));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = FILL_HDR;
        else          state_nxt_s = IDLE;
      end
      FILL_HDR: state_nxt_s = WFM_HDR;
      WFM_HDR: begin
        if (nb_left_r != '0) state_nxt_s = DATA;
        else                 state_nxt_s = CKSUM;
      end
      DATA: begin
        // nb_left counts down each DATA cycle; the last burst is when it is 1.
        if (nb_left_r == NB_W'(1)) state_nxt_s = CKSUM;
        else                       state_nxt_s = DATA;
      end
      CKSUM:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    select_fill_hdr     = 1'b0;
    select_waveform_hdr = 1'b0;
    select_dat          = 1'b0;
    select_checksum     = 1'b0;
    checksum_update     = 1'b0;
    busy                = 1'b1;
    case (state_r)
      IDLE:     busy = 1'b0;
      FILL_HDR: select_fill_hdr = 1'b1;
      WFM_HDR:  select_waveform_hdr = 1'b1;
      DATA: begin
        select_dat      = 1'b1;
        checksum_update = 1'b1;
      end
      CKSUM:    select_checksum = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  // Burst counter: loaded on accept, decremented through DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nb_left_r <= '0;
    end else if (accept_s) begin
      nb_left_r <= async_num_bursts;
    end else if (state_r == DATA) begin
      nb_left_r <= nb_left_r - NB_W'(1);
    end
  end

  // Fill bookkeeping: start address latch and fill counter (wraps naturally).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_start_adr <= 23'd0;
      fill_num        <= 24'd0;
    end else begin
      if (accept_s) burst_start_adr <= cbuf_wr_adr;
      if (state_r == CKSUM) fill_num <= fill_num + 24'd1;
    end
  end

  // The mux registers its word, so the write enable trails the select by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en   <= 1'b0;
      trig_dropped <= 1'b0;
    end else begin
      fifo_wr_en   <= select_fill_hdr | select_waveform_hdr | select_dat | select_checksum;
      trig_dropped <= drop_s;
    end
  end

`ifdef CBUF_DROP_COUNT_EN
  // Saturating count of rejected triggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_count <= 16'd0;
    end else if (drop_s && (dropped_count != 16'hFFFF)) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cbuf_acq_sequencer.sv
// Testbench for cbuf_acq_sequencer. Expected FIFO words (select code, write
// cycle, start address, fill number) are queued when a trigger is driven and
// popped when fifo_wr_en is observed.
module tb_cbuf_acq_sequencer;

  localparam int NB_W = 14;

  logic            clk;
  logic            rst;
  logic            trig;
  logic            enable;
  logic [NB_W-1:0] async_num_bursts;
  logic [22:0]     cbuf_wr_adr;
  logic            fifo_prog_full;
  logic            select_fill_hdr;
  logic            select_waveform_hdr;
  logic            select_dat;
  logic            select_checksum;
  logic            checksum_update;
  logic            fifo_wr_en;
  logic [22:0]     burst_start_adr;
  logic [23:0]     fill_num;
  logic            busy;
  logic            trig_dropped;
`ifdef CBUF_DROP_COUNT_EN
  logic [15:0]     dropped_count;
`endif

  cbuf_acq_sequencer #(.NB_W(NB_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .trig                (trig),
    .enable              (enable),
    .async_num_bursts    (async_num_bursts),
    .cbuf_wr_adr         (cbuf_wr_adr),
    .fifo_prog_full      (fifo_prog_full),
    .select_fill_hdr     (select_fill_hdr),
    .select_waveform_hdr (select_waveform_hdr),
    .select_dat          (select_dat),
    .select_checksum     (select_checksum),
    .checksum_update     (checksum_update),
    .fifo_wr_en          (fifo_wr_en),
    .burst_start_adr     (burst_start_adr),
    .fill_num            (fill_num),
    .busy                (busy),
`ifdef CBUF_DROP_COUNT_EN
    .trig_dropped        (trig_dropped),
    .dropped_count       (dropped_count)
`else
    .trig_dropped        (trig_dropped)
`endif
  );

  typedef struct {
    logic [3:0]  code;   // {fill, wfm, dat, cksum}
    int          cyc;
    logic [22:0] adr;
    logic [23:0] fill;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_bad;
  int          cyc;
  logic [23:0] model_fill;
  int          exp_drops;
  logic [3:0]  prev_code;
  logic [22:0] prev_adr;
  logic [23:0] prev_fill;
  logic [3:0]  cur_code;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time-stamp FIFO writes.
  always @(posedge clk) cyc <= cyc + 1;

  assign cur_code = {select_fill_hdr, select_waveform_hdr, select_dat, select_checksum};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: each FIFO write carries the word selected one cycle earlier.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wr", 32'd1, 32'd0);
      end else begin
        check("word_code", {28'd0, prev_code}, {28'd0, sb_q[0].code});
        check("word_cyc", cyc, sb_q[0].cyc);
        check("word_adr", {9'd0, prev_adr}, {9'd0, sb_q[0].adr});
        check("word_fill", {8'd0, prev_fill}, {8'd0, sb_q[0].fill});
        sb_q.delete(0);
      end
    end
    if (busy || checksum_update) begin
      check("cu_eq_dat", {31'd0, checksum_update}, {31'd0, select_dat});
      check("sel_onehot", $countones(cur_code), 32'd1);
    end
    prev_code <= cur_code;
    prev_adr  <= burst_start_adr;
    prev_fill <= fill_num;
  end

  // Called just after a negedge; returns one negedge later (state = FILL_HDR).
  task automatic start_fill(input int n, input logic [22:0] adr);
    int   k;
    exp_t e;
    k                = cyc + 1;
    trig             = 1'b1;
    enable           = 1'b1;
    fifo_prog_full   = 1'b0;
    async_num_bursts = 14'(n);
    cbuf_wr_adr      = adr;
    e.adr  = adr;
    e.fill = model_fill;
    e.code = 4'b1000; e.cyc = k + 1; sb_q.push_back(e);
    e.code = 4'b0100; e.cyc = k + 2; sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.code = 4'b0010; e.cyc = k + 3 + i; sb_q.push_back(e);
    end
    e.code = 4'b0001; e.cyc = k + 3 + n; sb_q.push_back(e);
    model_fill = model_fill + 24'd1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy || fifo_wr_en || sb_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t = t + 1;
    end
    check(tag, {31'd0, (t < 200)}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {24'd0, cur_code, checksum_update, fifo_wr_en, busy, trig_dropped}, 32'd0);
    check({tag, "_adr"}, {9'd0, burst_start_adr}, 32'd0);
    check({tag, "_fill"}, {8'd0, fill_num}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; model_fill = 24'd0; exp_drops = 0;
    rst = 1'b1; trig = 1'b0; enable = 1'b0; fifo_prog_full = 1'b0;
    async_num_bursts = 14'd0; cbuf_wr_adr = 23'd0;
    #3;
    check_all_zero("reset");
`ifdef CBUF_DROP_COUNT_EN
    check("reset_dropcnt", {16'd0, dropped_count}, 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic fill, N=4.
    start_fill(4, 23'h000abc);
    wait_idle("basic_done");
    check("basic_fill_num", {8'd0, fill_num}, {8'd0, model_fill});

    // Zero bursts: FILL_HDR, WFM_HDR, CKSUM only.
    start_fill(0, 23'h000010);
    wait_idle("zero_done");

    // Trigger while busy is dropped; back-to-back trigger in first IDLE cycle.
    start_fill(2, 23'h000200);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    exp_drops = exp_drops + 1;
    check("busy_drop_pulse", {31'd0, trig_dropped}, 32'd1);
    @(negedge clk);
    check("busy_drop_once", {31'd0, trig_dropped}, 32'd0);
    repeat (1 + 2) @(negedge clk);
    check("b2b_idle", {31'd0, busy}, 32'd0);
`ifdef CBUF_DROP_COUNT_EN
    check("dropcnt_1", {16'd0, dropped_count}, exp_drops);
`endif
    start_fill(1, 23'h000300);
    wait_idle("b2b_done");

    // FIFO full: dropped, nothing selected.
    fifo_prog_full = 1'b1; enable = 1'b1; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    exp_drops = exp_drops + 1;
    check("full_drop_pulse", {31'd0, trig_dropped}, 32'd1);
    check("full_not_busy", {31'd0, busy}, 32'd0);
    fifo_prog_full = 1'b0;
    // enable low in IDLE: silently ignored.
    enable = 1'b0; trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    check("dis_no_pulse", {31'd0, trig_dropped}, 32'd0);
    check("dis_not_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
`ifdef CBUF_DROP_COUNT_EN
    check("dropcnt_2", {16'd0, dropped_count}, exp_drops);
`endif

    // Latching: inputs and enable change mid-fill without effect.
    start_fill(3, 23'h123456);
    cbuf_wr_adr = 23'h7fffff; async_num_bursts = 14'd9; enable = 1'b0;
    @(negedge clk);
    check("latched_adr", {9'd0, burst_start_adr}, 32'h123456);
    wait_idle("latch_done");
    check("latched_hold", {9'd0, burst_start_adr}, 32'h123456);

    // Asynchronous reset during DATA.
    start_fill(5, 23'h000777);
    repeat (3) @(negedge clk);
    check("in_data", {31'd0, select_dat}, 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    sb_q.delete();
    model_fill = 24'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_fill(2, 23'h000042);
    wait_idle("post_reset_done");
    check("post_reset_fill", {8'd0, fill_num}, 32'd1);

    // Fill counter wrap from a preloaded 0xFFFFFF.
    force dut.fill_num = 24'hffffff;
    @(negedge clk);
    release dut.fill_num;
    model_fill = 24'hffffff;
    @(negedge clk);
    start_fill(1, 23'h000055);
    wait_idle("wrap_done");
    check("wrap_fill", {8'd0, fill_num}, 32'd0);

    check("queue_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
